fir_mac_sequencer: RTL and testbench

//  Time-multiplexed FIR engine for one equaliser band: one saturating Q(magnitud).(precision) multiplier is shared across all TAPS.
//  Per accepted sample: shift delay line, then sequence TAPS multiply-accumulates (one per clock), emit one saturated output sample.

---
 rtl/fir_mac_sequencer_pkg.sv | 19 +
 rtl/fir_mac_sequencer_sat_add_q.sv | 27 ++
 rtl/fir_mac_sequencer.sv | 157 +++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared fixed-point defaults and FSM encoding for the equaliser-band FIR engine.
package fir_mac_sequencer_pkg;

  localparam int ANCHO_DEF     = 20;
  localparam int MAGNITUD_DEF  = 5;
  localparam int PRECISION_DEF = 14;
  localparam int TAPS_DEF      = 8;

  localparam logic [ANCHO_DEF-1:0] Q_MAX = 20'h7FFFF;
  localparam logic [ANCHO_DEF-1:0] Q_MIN = 20'h80000;
  localparam logic [ANCHO_DEF-1:0] Q_ONE = 20'h04000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_sat_add_q.sv
// Combinational saturating two's-complement adder used by the FIR accumulator.
module sat_add_q
  import fir_mac_sequencer_pkg::*;
#(
  parameter int ancho = ANCHO_DEF
) (
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  output logic [ancho-1:0] y
);

  localparam logic [ancho-1:0] SAT_MAX = {1'b0, {(ancho-1){1'b1}}};
  localparam logic [ancho-1:0] SAT_MIN = {1'b1, {(ancho-1){1'b0}}};

  logic [ancho-1:0] sum;

  assign sum = a + b;

  // Overflow is only possible when both operands share a sign and the sum flips it.
  always_comb begin
    y = sum;
    if ((a[ancho-1] == b[ancho-1]) && (sum[ancho-1] != a[ancho-1])) begin
      y = a[ancho-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one saturating multiplier and accumulator shared across all taps,
// one tap per clock, one saturated output per accepted sample.
module fir_mac_sequencer
  import fir_mac_sequencer_pkg::*;
#(
  parameter int ancho     = ANCHO_DEF,
  parameter int magnitud  = MAGNITUD_DEF,
  parameter int precision = PRECISION_DEF,
  parameter int TAPS      = TAPS_DEF,
  localparam int IW       = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ancho-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             coef_wr_en,
  input  logic [IW-1:0]    coef_wr_addr,
  input  logic [ancho-1:0] coef_wr_data,
  output logic [ancho-1:0] y_out,
  output logic             y_valid,
  output logic             busy,
  output logic             sample_drop,
  output logic             coef_wr_reject
);

  localparam int PW     = 2 * ancho;
  localparam int OVF_LO = 2 * precision + magnitud;
  localparam logic [ancho-1:0] SAT_MAX  = {1'b0, {(ancho-1){1'b1}}};
  localparam logic [ancho-1:0] SAT_MIN  = {1'b1, {(ancho-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_LAST = IW'(TAPS - 1);

  state_t           state_reg;
  logic [IW-1:0]    idx_reg;
  logic [ancho-1:0] acc_reg;
  logic [ancho-1:0] y_out_reg;
  logic             y_valid_reg;
  logic             busy_reg;
  logic             sample_drop_reg;
  logic             coef_wr_reject_reg;

  logic [ancho-1:0] x_reg  [TAPS];
  logic [ancho-1:0] x_next [TAPS];
  logic [ancho-1:0] h_reg  [TAPS];
  logic [ancho-1:0] h_next [TAPS];

  logic addr_ok;
  logic shift_en;
  logic coef_we;

  assign addr_ok  = ({1'b0, coef_wr_addr} < (IW+1)'(TAPS));
  assign shift_en = (state_reg == IDLE) && sample_valid;
  assign coef_we  = (state_reg == IDLE) && coef_wr_en && addr_ok;

  // Coefficient writes and the delay-line shift share one edge, so a write issued
  // together with a sample is already visible to the first MAC of that sequence.
  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign x_next[gi] = shift_en ? sample_in : x_reg[gi];
      end else begin : g_body
        assign x_next[gi] = shift_en ? x_reg[gi-1] : x_reg[gi];
      end
      assign h_next[gi] = (coef_we && (coef_wr_addr == IW'(gi))) ? coef_wr_data : h_reg[gi];
    end
  endgenerate

  logic signed [ancho-1:0]      mul_a;
  logic signed [ancho-1:0]      mul_b;
  logic signed [PW-1:0]         prod;
  logic        [PW-1-OVF_LO:0]  ovf;
  logic        [ancho-1:0]      mul_q;
  logic        [ancho-1:0]      acc_sum;
  logic                         unused_prod_lsb;

  assign mul_a           = x_reg[idx_reg];
  assign mul_b           = h_reg[idx_reg];
  assign prod            = mul_a * mul_b;
  assign ovf             = prod[PW-1:OVF_LO];
  assign unused_prod_lsb = ^prod[precision-1:0];

  // Truncating Q-format multiply; bits above the result's integer field must all
  // match the product sign, otherwise clamp toward that sign.
  always_comb begin
    mul_q = {prod[PW-1], prod[OVF_LO-1:precision]};
    if ((mul_a == '0) || (mul_b == '0)) begin
      mul_q = '0;
    end else if (mul_a[ancho-1] == mul_b[ancho-1]) begin
      if (|ovf) mul_q = SAT_MAX;
    end else if (!(&ovf)) begin
      mul_q = SAT_MIN;
    end
  end

  sat_add_q #(
    .ancho(ancho)
  ) u_acc_add (
    .a(acc_reg),
    .b(mul_q),
    .y(acc_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      idx_reg            <= '0;
      acc_reg            <= '0;
      y_out_reg          <= '0;
      y_valid_reg        <= 1'b0;
      busy_reg           <= 1'b0;
      sample_drop_reg    <= 1'b0;
      coef_wr_reject_reg <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i] <= '0;
        h_reg[i] <= '0;
      end
    end else begin
      x_reg              <= x_next;
      h_reg              <= h_next;
      y_valid_reg        <= 1'b0;
      sample_drop_reg    <= sample_valid && (state_reg != IDLE);
      coef_wr_reject_reg <= coef_wr_en && addr_ok && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_sum;
          if (idx_reg == IDX_LAST) begin
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          y_out_reg   <= acc_reg;
          y_valid_reg <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign y_out          = y_out_reg;
  assign y_valid        = y_valid_reg;
  assign busy           = busy_reg;
  assign sample_drop    = sample_drop_reg;
  assign coef_wr_reject = coef_wr_reject_reg;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: vector table, scoreboard queue and corner sequences.
module tb_fir_mac_sequencer;

  localparam int TAPS = 8;
  localparam int W    = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          coef_wr_en = 1'b0;
  logic [2:0]    coef_wr_addr = '0;
  logic [W-1:0]  coef_wr_data = '0;
  logic [W-1:0]  y_out;
  logic          y_valid;
  logic          busy;
  logic          sample_drop;
  logic          coef_wr_reject;

  always #5 clk = ~clk;

  fir_mac_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data),
    .y_out(y_out),
    .y_valid(y_valid),
    .busy(busy),
    .sample_drop(sample_drop),
    .coef_wr_reject(coef_wr_reject)
  );

  typedef struct {
    logic [W-1:0] sample;
    logic [W-1:0] exp_y;
  } vec_t;

  vec_t         vecs [8];
  logic [W-1:0] mx [TAPS];
  logic [W-1:0] mh [TAPS];
  logic [W-1:0] sb_q [$];
  int           errors = 0;
  int           checks = 0;

  function automatic longint clampl(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  function automatic longint mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return clampl(p >>> 14);
  endfunction

  function automatic logic [W-1:0] model_y();
    longint acc;
    logic [63:0] r;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc = clampl(acc + mul_ref(mx[k], mh[k]));
    r = acc;
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor: every y_valid strobe must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && y_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_y_valid: got y_out=%h expected no strobe at %0t", y_out, $time);
      end else begin
        check("sb_y_out", y_out, sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_valid = 1'b0;
    coef_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = '0;
      mh[k] = '0;
    end
  endtask

  task automatic wr_coef(input logic [2:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    coef_wr_en = 1'b1;
    coef_wr_addr = addr;
    coef_wr_data = data;
    mh[addr] = data;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  // Drives one sample (optionally with a same-cycle coefficient write) and returns in cycle t+1.
  task automatic send(input logic [W-1:0] s, input bit do_wr, input logic [2:0] addr,
                      input logic [W-1:0] data);
    @(negedge clk);
    sample_in = s;
    sample_valid = 1'b1;
    if (do_wr) begin
      coef_wr_en = 1'b1;
      coef_wr_addr = addr;
      coef_wr_data = data;
      mh[addr] = data;
    end
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
    sb_q.push_back(model_y());
    @(negedge clk);
    sample_valid = 1'b0;
    coef_wr_en = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL result_timeout: got %0d pending results expected 0", sb_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].sample = (i == 0) ? 20'h04000 : 20'h00000;
      vecs[i].exp_y  = W'(i * 20'h00800);
    end

    do_reset();
    check("rst_y_out", y_out, '0);
    check("rst_y_valid", {19'd0, y_valid}, '0);
    check("rst_busy", {19'd0, busy}, '0);
    check("rst_sample_drop", {19'd0, sample_drop}, '0);
    check("rst_coef_wr_reject", {19'd0, coef_wr_reject}, '0);

    // Latency and busy window for a single unit-gain tap.
    wr_coef(3'd0, 20'h04000);
    @(negedge clk);
    sample_in = 20'h02000;
    sample_valid = 1'b1;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = 20'h02000;
    sb_q.push_back(model_y());
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      check($sformatf("t1_busy_c%0d", n), {19'd0, busy}, {19'd0, (n <= 9)});
      check($sformatf("t1_y_valid_c%0d", n), {19'd0, y_valid}, {19'd0, (n == 10)});
    end
    check("t1_y_out", y_out, 20'h02000);

    // Impulse through a ramp of coefficients, table driven.
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(3'(k), W'(k * 20'h00800));
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].sample, 1'b0, 3'd0, '0);
      wait_done();
      check($sformatf("t2_vec%0d", i), y_out, vecs[i].exp_y);
    end

    // Accumulator saturation in both directions.
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(3'(k), 20'h04000);
    for (int i = 0; i < 8; i++) begin
      send(20'h7FFFF, 1'b0, 3'd0, '0);
      wait_done();
    end
    check("t3_pos_sat", y_out, 20'h7FFFF);
    for (int i = 0; i < 8; i++) begin
      send(20'h80000, 1'b0, 3'd0, '0);
      wait_done();
    end
    check("t3_neg_sat", y_out, 20'h80000);

    // Samples arriving during MAC and during DONE are dropped.
    do_reset();
    wr_coef(3'd0, 20'h04000);
    @(negedge clk);
    sample_in = 20'h02000;
    sample_valid = 1'b1;
    mx[0] = 20'h02000;
    sb_q.push_back(model_y());
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      check($sformatf("t4_drop_c%0d", n), {19'd0, sample_drop}, {19'd0, (n == 4 || n == 10)});
      sample_valid = (n == 3 || n == 9);
      sample_in = 20'h01234;
    end
    sample_valid = 1'b0;
    wait_done();
    check("t4_y_out", y_out, 20'h02000);
    wr_coef(3'd1, 20'h04000);
    send(20'h00000, 1'b0, 3'd0, '0);
    wait_done();
    check("t4_no_leak", y_out, 20'h02000);

    // Coefficient write rejected while busy, honoured in IDLE alongside a sample.
    do_reset();
    wr_coef(3'd0, 20'h04000);
    send(20'h02000, 1'b0, 3'd0, '0);
    @(negedge clk);
    coef_wr_en = 1'b1;
    coef_wr_addr = 3'd0;
    coef_wr_data = 20'h02000;
    @(negedge clk);
    coef_wr_en = 1'b0;
    check("t5_reject", {19'd0, coef_wr_reject}, 20'd1);
    @(negedge clk);
    check("t5_reject_clear", {19'd0, coef_wr_reject}, '0);
    wait_done();
    check("t5_h_unchanged", y_out, 20'h02000);
    send(20'h02000, 1'b1, 3'd0, 20'h02000);
    check("t5_no_reject_idle", {19'd0, coef_wr_reject}, '0);
    wait_done();
    check("t5_write_used", y_out, 20'h01000);

    // Reset mid-sequence aborts without a result.
    do_reset();
    wr_coef(3'd0, 20'h04000);
    send(20'h04000, 1'b0, 3'd0, '0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = '0;
      mh[k] = '0;
    end
    check("t6_y_out", y_out, '0);
    check("t6_y_valid", {19'd0, y_valid}, '0);
    check("t6_busy", {19'd0, busy}, '0);
    check("t6_sample_drop", {19'd0, sample_drop}, '0);
    check("t6_coef_wr_reject", {19'd0, coef_wr_reject}, '0);
    repeat (15) @(negedge clk);
    send(20'h04000, 1'b0, 3'd0, '0);
    wait_done();
    check("t6_h0_cleared", y_out, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
